// File: rtl/rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_loader_pkg
// Shared definitions for the ROM loader and the program memory it fills:
// default memory geometry, the loader FSM state encoding and the
// bytes-per-word helper used to size the byte packer.
// No ports (package).
// -----------------------------------------------------------------------------
package rom_loader_pkg;

   // Default geometry, shared with the instruction ROM.
   localparam int MEM_WIDTH  = 16;
   localparam int MEM_LENGTH = 32;
   localparam int ADD_LENGTH = 5;

   localparam int BYTES_PER_WORD = MEM_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      CSUM,
      DONE
   } state_t;

   // Bytes per word for an arbitrary (multiple-of-8) word width.
   function automatic int bytes_per_word(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/rom_loader_packer.sv
// -----------------------------------------------------------------------------
// rom_loader_packer
// Assembles a byte stream into mem_width-bit words, big-endian: the first
// byte of a word ends up in the most significant byte.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   clear      synchronous restart of the byte index (new load)
//   shift_en   a byte is accepted this cycle
//   byte_in    accepted byte
//   word       assembled word (complete once word_full has been seen)
//   word_full  this cycle's accepted byte completes the word
// -----------------------------------------------------------------------------
module rom_loader_packer
   import rom_loader_pkg::*;
#(
   parameter int mem_width = MEM_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 shift_en,
   input  logic [7:0]           byte_in,
   output logic [mem_width-1:0] word,
   output logic                 word_full
);

   localparam int BPW   = bytes_per_word(mem_width);
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [IDX_W-1:0] idx_q;

   // Combinational so the FSM can leave LOAD on the very edge that takes the
   // last byte of the word.
   assign word_full = shift_en && (idx_q == IDX_W'(BPW - 1));

   // NOTE: the word register is a handful of flops, not a memory array, so it
   // is cheap to reset and doing so discards any partial word on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
         word  <= '0;
      end else if (clear) begin
         idx_q <= '0;
      end else if (shift_en) begin
         idx_q <= word_full ? '0 : idx_q + IDX_W'(1);
         // Older bytes move toward the MSB, so the first byte lands on top.
         word  <= (word << 8) | mem_width'(byte_in);
      end
   end

endmodule

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Fills a writable program memory (mem_width x mem_length) from a byte
// stream. Bytes are packed big-endian into words, each word is written with a
// single-cycle strobe at sequential addresses starting at 0, and the CPU is
// held in stall (cpu_hold) for the whole load.
// Optional build macro: CHECKSUM_EN -- after the last word one checksum byte
// is accepted and compared with the XOR of all data bytes; err flags a
// mismatch. Without the macro err is constant 0.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start                one-cycle load request, honoured in IDLE only
//   load_len             words to load; 0 or > mem_length means mem_length
//   in_valid, in_data    byte stream; in_ready says a byte can be taken
//   wr_en/addr/data      memory write port
//   cpu_hold             CPU stall, from start acceptance through DONE
//   done                 one-cycle completion pulse
//   err                  checksum mismatch, held until the next start
// -----------------------------------------------------------------------------
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int mem_width  = MEM_WIDTH,
   parameter int mem_length = MEM_LENGTH,
   parameter int add_length = ADD_LENGTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [add_length:0]   load_len,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [add_length-1:0] wr_addr,
   output logic [mem_width-1:0]  wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam logic [add_length:0] MAX_LEN = (add_length + 1)'(mem_length);

   state_t                state, state_next;
   logic [add_length-1:0] addr_q;
   logic [add_length:0]   len_q;
   logic [add_length:0]   len_eff;
   logic                  start_ok;
   logic                  accept;
   logic                  byte_load;
   logic                  word_full;
   logic                  last_word;

   assign start_ok  = (state == IDLE) && start;
   assign accept    = in_valid && in_ready;
   assign byte_load = accept && (state == LOAD);
   assign len_eff   = ((load_len == '0) || (load_len > MAX_LEN)) ? MAX_LEN : load_len;
   // The word at addr_q is the last one when addr_q + 1 reaches the length,
   // which keeps wr_addr within 0..len-1 with no wrap.
   assign last_word = ((add_length + 1)'(addr_q) + (add_length + 1)'(1)) == len_q;

   rom_loader_packer #(
      .mem_width (mem_width)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .shift_en  (byte_load),
      .byte_in   (in_data),
      .word      (wr_data),
      .word_full (word_full)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         len_q  <= '0;
      end else if (start_ok) begin
         addr_q <= '0;
         len_q  <= len_eff;
      end else if ((state == WRITE) && !last_word) begin
         addr_q <= addr_q + add_length'(1);
      end
   end

   // NOTE: state_next is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start_ok) state_next = LOAD;
         LOAD:  if (word_full) state_next = WRITE;
         WRITE: begin
            if (!last_word)     state_next = LOAD;
`ifdef CHECKSUM_EN
            else                state_next = CSUM;
`else
            else                state_next = DONE;
`endif
         end
         CSUM:  if (accept) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready = (state == LOAD) || (state == CSUM);
   assign wr_en    = (state == WRITE);
   assign wr_addr  = addr_q;
   assign cpu_hold = (state != IDLE);
   assign done     = (state == DONE);

`ifdef CHECKSUM_EN
   logic [7:0] xor_q;
   logic       err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xor_q <= '0;
         err_q <= 1'b0;
      end else if (start_ok) begin
         xor_q <= '0;
         err_q <= 1'b0;
      end else if (byte_load) begin
         xor_q <= xor_q ^ in_data;
      end else if ((state == CSUM) && accept) begin
         err_q <= (in_data != xor_q);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
// Self-checking bench for rom_loader. Inputs are driven just after the falling
// edge and outputs sampled on the falling edge. Expected memory contents are
// derived from the byte list: word i takes bytes i*BPW.. with the first byte
// in the top byte lane.
// -----------------------------------------------------------------------------
module tb_rom_loader;
   import rom_loader_pkg::*;

   localparam int W   = MEM_WIDTH;
   localparam int L   = MEM_LENGTH;
   localparam int A   = ADD_LENGTH;
   localparam int BPW = W / 8;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [A:0]   load_len = '0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_ready;
   logic         wr_en;
   logic [A-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic         cpu_hold;
   logic         done;
   logic         err;

   int  checks = 0;
   int  errors = 0;
   int  viol   = 0;
   wr_t wq[$];

   always #5 clk = ~clk;

   rom_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .load_len (load_len),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   // Write monitor: records every strobe and counts protocol violations.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) wq.push_back('{addr: wr_addr, data: wr_data});
         if (wr_en && in_ready) viol++;
         if (wr_en && (int'(wr_addr) > L - 1)) viol++;
      end
   end

   // ---------------- reference model ----------------
   function automatic int eff_len(input int len);
      return ((len == 0) || (len > L)) ? L : len;
   endfunction

   function automatic logic [W-1:0] model_word(input byte_q_t b, input int i);
      logic [W-1:0] w = '0;
      for (int k = 0; k < BPW; k++) w[W-1-8*k -: 8] = b[i*BPW + k];
      return w;
   endfunction

   function automatic logic [7:0] model_xor(input byte_q_t b, input int cnt);
      logic [7:0] x = '0;
      for (int i = 0; i < cnt; i++) x ^= b[i];
      return x;
   endfunction

   function automatic byte_q_t rand_bytes(input int cnt);
      byte_q_t q;
      for (int i = 0; i < cnt; i++) q.push_back(8'($urandom_range(255, 0)));
      return q;
   endfunction

   // ---------------- drivers ----------------
   task automatic do_start(input int len);
      start    = 1'b1;
      load_len = (A + 1)'(len);
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Presents a byte after 'gap' idle cycles and returns on the falling edge
   // following the rising edge that accepted it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_byte: in_ready stayed %b, required 1 within 50 cycles", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_csum(input byte_q_t b, input int cnt, input bit bad);
`ifdef CHECKSUM_EN
      logic [7:0] x = model_xor(b, cnt);
      send_byte(bad ? (x ^ 8'h01) : x, 0);
`endif
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Completion and memory-image comparison for one load.
   task automatic verify_load(input int n, input byte_q_t b, input bit bad,
                              input int v0, input string name);
      logic exp_err;
`ifdef CHECKSUM_EN
      exp_err = bad;
`else
      exp_err = 1'b0;
`endif
      wait_done(20);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done: got %b, required 1 within budget", name, done);
      end
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL %s err: got %b, required %b", name, err, exp_err);
      end
      @(negedge clk);
      checks++;
      if (cpu_hold !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s hold_after: got hold=%b done=%b, required 0 0", name, cpu_hold, done);
      end
      checks++;
      if (wq.size() != n) begin
         errors++;
         $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), n);
      end
      for (int i = 0; i < n && i < wq.size(); i++) begin
         checks++;
         if (wq[i].addr !== A'(i) || wq[i].data !== model_word(b, i)) begin
            errors++;
            $display("FAIL %s write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                     name, i, wq[i].addr, wq[i].data, i, model_word(b, i));
         end
      end
      checks++;
      if (viol != v0) begin
         errors++;
         $display("FAIL %s protocol: got %0d violations, required 0", name, viol - v0);
      end
   endtask

   task automatic run_load(input int len, input byte_q_t b, input int max_gap,
                           input bit bad, input string name);
      int n  = eff_len(len);
      int v0 = viol;
      wq.delete();
      do_start(len);
      for (int i = 0; i < n * BPW; i++) send_byte(b[i], $urandom_range(max_gap, 0));
      send_csum(b, n * BPW, bad);
      verify_load(n, b, bad, v0, name);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b wr_en=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL idle_outputs: got ready=%b hold=%b, required 0 0", in_ready, cpu_hold);
      end
   endtask

   task automatic test_single_word();
      wq.delete();
      do_start(1);
      checks++;
      if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single hold_on_start: got hold=%b ready=%b, required 1 1", cpu_hold, in_ready);
      end
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 16'hABCD) begin
         errors++;
         $display("FAIL single write: got wr_en=%b addr=%0d data=%h, required 1 0 abcd",
                  wr_en, wr_addr, wr_data);
      end
`ifdef CHECKSUM_EN
      send_byte(8'hAB ^ 8'hCD, 0);
`else
      @(negedge clk);
`endif
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL single done: got done=%b hold=%b err=%b, required 1 1 0", done, cpu_hold, err);
      end
      @(negedge clk);
      checks++;
      if (cpu_hold !== 1'b0 || done !== 1'b0 || wq.size() != 1) begin
         errors++;
         $display("FAIL single after: got hold=%b done=%b writes=%0d, required 0 0 1",
                  cpu_hold, done, wq.size());
      end
   endtask

   task automatic test_full_memory();
      byte_q_t b;
      for (int i = 0; i < L * BPW; i++) b.push_back(8'(i));
      run_load(0, b, 0, 1'b0, "full");
      checks++;
      if (wq.size() != L || wq[L-1].data !== 16'h3E3F) begin
         errors++;
         $display("FAIL full last_word: got writes=%0d last=%h, required %0d 3e3f",
                  wq.size(), (wq.size() > 0) ? wq[wq.size()-1].data : '0, L);
      end
   endtask

   task automatic test_backpressure();
      byte_q_t b = rand_bytes(2 * BPW);
      int v0 = viol;
      wq.delete();
      do_start(2);
      send_byte(b[0], 0);
      send_byte(b[1], 2);
      checks++;
      if (wr_en !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp write_stall: got wr_en=%b ready=%b, required 1 0", wr_en, in_ready);
      end
      send_byte(b[2], 0);  // presented during WRITE, must wait
      send_byte(b[3], 1);
      send_csum(b, 2 * BPW, 1'b0);
      verify_load(2, b, 1'b0, v0, "backpressure");
   endtask

   task automatic test_ignored_start();
      byte_q_t b = rand_bytes(4 * BPW);
      int v0 = viol;
      wq.delete();
      do_start(4);
      for (int i = 0; i < 3; i++) send_byte(b[i], 0);
      start    = 1'b1;
      load_len = (A + 1)'(1);
      @(negedge clk);
      start    = 1'b0;
      for (int i = 3; i < 4 * BPW; i++) send_byte(b[i], $urandom_range(1, 0));
      send_csum(b, 4 * BPW, 1'b0);
      verify_load(4, b, 1'b0, v0, "ignored_start");
   endtask

   task automatic test_clamp();
      run_load(40, rand_bytes(L * BPW), 1, 1'b0, "clamp40");
   endtask

   task automatic test_reset_mid_load();
      byte_q_t b = rand_bytes(4 * BPW);
      do_start(4);
      for (int i = 0; i < 3; i++) send_byte(b[i], 0);
      reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== '0) begin
         errors++;
         $display("FAIL midreset outputs: got ready=%b wr_en=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_load(2, rand_bytes(2 * BPW), 2, 1'b0, "after_reset");
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      byte_q_t b = '{8'h12, 8'h34};
      int v0 = viol;
      wq.delete();
      do_start(1);
      send_byte(b[0], 0);
      send_byte(b[1], 0);
      send_byte(8'h26, 0);
      verify_load(1, b, 1'b0, v0, "csum_good");
      wq.delete();
      v0 = viol;
      do_start(1);
      send_byte(b[0], 0);
      send_byte(b[1], 1);
      send_byte(8'h27, 0);
      verify_load(1, b, 1'b1, v0, "csum_bad");
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL csum err_held: got %b, required 1", err);
      end
      do_start(1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL csum err_clear: got %b, required 0", err);
      end
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      wait_done(20);
      @(negedge clk);
   endtask
`endif

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int len = $urandom_range(40, 0);
         run_load(len, rand_bytes(L * BPW), 2, 1'($urandom_range(1, 0)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_memory();
      test_backpressure();
      test_ignored_start();
      test_clamp();
      test_reset_mid_load();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
